// File: rtl/warp_sequencer.sv
// Per-warp control FSM: owns the warp PC, the fetch handshake and the LSU start pulse.
// Optional perf counters are compiled in with `define WARP_SEQUENCER_PERF_COUNTERS_EN.
package warp_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } warp_state_t;
endpackage

module warp_sequencer
  import warp_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  output logic                   enable,
  output warp_state_t            warp_state,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   fetch_req,
  input  logic                   fetch_valid,
  input  logic [INSTR_WIDTH-1:0] fetch_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   decoded_mem_access,
  input  logic                   decoded_branch,
  input  logic                   decoded_halt,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   lsu_req,
  input  logic                   lsu_done,
  output logic                   done
`ifdef WARP_SEQUENCER_PERF_COUNTERS_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_instr_retired
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  warp_state_t            state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   taken_q, taken_d;
  logic [PC_WIDTH-1:0]    target_q, target_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    taken_d   = taken_q;
    target_d  = target_q;
    fetch_req = 1'b0;
    lsu_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_valid) begin
          instr_d = fetch_data;
          state_d = DECODE;
        end
      end
      DECODE:  state_d = REQUEST;
      REQUEST: begin
        lsu_req = decoded_mem_access;
        state_d = WAIT;
      end
      // Non-memory instructions pass straight through; lsu_done only matters for loads/stores
      WAIT: begin
        if (!decoded_mem_access || lsu_done) state_d = EXECUTE;
      end
      EXECUTE: begin
        taken_d  = branch_taken;
        target_d = branch_target;
        state_d  = UPDATE;
      end
      UPDATE: begin
        if (decoded_halt) begin
          state_d = DONE;
        end else begin
          pc_d    = (decoded_branch && taken_q) ? target_q : pc_q + PC_ONE;
          state_d = FETCH;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Branch outcome is only meaningful at the EXECUTE edge, so it needs no reset
  always_ff @(posedge clk) begin
    taken_q  <= taken_d;
    target_q <= target_d;
  end

  assign warp_state  = state_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign enable      = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);

`ifdef WARP_SEQUENCER_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] cycles_q, cycles_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    cycles_d  = enable ? sat_inc(cycles_q) : cycles_q;
    retired_d = retired_q;
    // Halting instructions leave UPDATE for DONE and are not counted as retired
    if (state_q == UPDATE && !decoded_halt) retired_d = sat_inc(retired_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
    end
  end

  assign perf_cycles        = cycles_q;
  assign perf_instr_retired = retired_q;
`endif

endmodule
